// File: rtl/fat32_root_dir_scanner_pkg.sv
// -----------------------------------------------------------------------------
// fat32_pkg
// Shared constants and types for the FAT32 root-directory scanner.
//   - Directory entry layout offsets (32-byte short-name entries)
//   - Attribute / first-byte marker values
//   - Scanner FSM state type
// -----------------------------------------------------------------------------
package fat32_pkg;

    localparam int ENTRY_BYTES     = 32;
    localparam int DIR_OFS_ATTR    = 11;
    localparam int DIR_OFS_CLUS_HI = 20;
    localparam int DIR_OFS_CLUS_LO = 26;
    localparam int DIR_OFS_SIZE    = 28;

    localparam logic [7:0] ATTR_LFN      = 8'h0F;
    localparam int         ATTR_VOLUME   = 3;      // bit index of volume-label flag
    localparam logic [7:0] ENTRY_FREE    = 8'h00;
    localparam logic [7:0] ENTRY_DELETED = 8'hE5;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_REQ    = 3'd1,
        ST_STREAM = 3'd2,
        ST_EVAL   = 3'd3,
        ST_DONE   = 3'd4
    } scan_state_e;

endpackage

// File: rtl/fat32_root_dir_scanner_matcher.sv
// -----------------------------------------------------------------------------
// dir_entry_matcher
// Parses one 32-byte directory entry as it streams past and raises strobes on
// the entry's final byte (offset 31).
// Optional macro: FAT32_DIR_CASE_FOLD_EN folds lower-case name bytes
// (0x61-0x7A) to upper case before comparing against TARGET_NAME.
//
// Ports:
//   clk           : clock
//   beat_i        : current byte is valid and belongs to a directory stream
//   ofs_i[4:0]    : byte offset within the current entry
//   byte_i[7:0]   : entry byte
//   entry_done_o  : last byte of an entry on this beat
//   skip_o        : entry is deleted, LFN or volume label
//   end_o         : entry marks end of directory (first byte 0x00)
//   match_o       : live entry whose name equals TARGET_NAME
//   name_eq_o     : all 11 name bytes matched so far
//   clus_o[31:0]  : first cluster {b21,b20,b27,b26}
//   size_o[31:0]  : file size, bytes 31..28 little-endian
// -----------------------------------------------------------------------------
module dir_entry_matcher
    import fat32_pkg::*;
#(
    parameter logic [87:0] TARGET_NAME = 88'h44_41_54_41_20_20_20_20_42_49_4E
) (
    input  logic        clk,
    input  logic        beat_i,
    input  logic [4:0]  ofs_i,
    input  logic [7:0]  byte_i,
    output logic        entry_done_o,
    output logic        skip_o,
    output logic        end_o,
    output logic        match_o,
    output logic        name_eq_o,
    output logic [31:0] clus_o,
    output logic [31:0] size_o
);

    function automatic logic [7:0] fold_case(input logic [7:0] b);
`ifdef FAT32_DIR_CASE_FOLD_EN
        if (b >= 8'h61 && b <= 8'h7A) return b - 8'h20;
        else                          return b;
`else
        return b;
`endif
    endfunction

    function automatic logic [7:0] target_byte(input int idx);
        return TARGET_NAME[(10 - idx) * 8 +: 8];
    endfunction

    logic       name_eq_q;
    logic [7:0] b0_q;
    logic [7:0] attr_q;
    logic [7:0] clus_b20_q, clus_b21_q, clus_b26_q, clus_b27_q;
    logic [7:0] size_b28_q, size_b29_q, size_b30_q;

    // Field capture; every field is rewritten inside each entry before it is
    // consumed at offset 31, so no reset is needed on this datapath.
    always_ff @(posedge clk) begin
        if (beat_i) begin
            if (ofs_i == 5'd0) begin
                b0_q      <= byte_i;
                name_eq_q <= (fold_case(byte_i) == target_byte(0));
            end else if (ofs_i <= 5'd10) begin
                name_eq_q <= name_eq_q && (fold_case(byte_i) == target_byte(int'(ofs_i)));
            end
            case (int'(ofs_i))
                DIR_OFS_ATTR:        attr_q     <= byte_i;
                DIR_OFS_CLUS_HI:     clus_b20_q <= byte_i;
                DIR_OFS_CLUS_HI + 1: clus_b21_q <= byte_i;
                DIR_OFS_CLUS_LO:     clus_b26_q <= byte_i;
                DIR_OFS_CLUS_LO + 1: clus_b27_q <= byte_i;
                DIR_OFS_SIZE:        size_b28_q <= byte_i;
                DIR_OFS_SIZE + 1:    size_b29_q <= byte_i;
                DIR_OFS_SIZE + 2:    size_b30_q <= byte_i;
                default: ;
            endcase
        end
    end

    always_comb begin
        entry_done_o = beat_i && (ofs_i == 5'(ENTRY_BYTES - 1));
        end_o        = entry_done_o && (b0_q == ENTRY_FREE);
        // LFN (0x0F) also has the volume bit set; both are kept for clarity.
        skip_o       = entry_done_o && !end_o &&
                       ((b0_q == ENTRY_DELETED) || (attr_q == ATTR_LFN) || attr_q[ATTR_VOLUME]);
        name_eq_o    = name_eq_q;
        match_o      = entry_done_o && !end_o && !skip_o && name_eq_q;
        clus_o       = {clus_b21_q, clus_b20_q, clus_b27_q, clus_b26_q};
        // Byte 31 is the current beat when the strobes fire.
        size_o       = {byte_i, size_b30_q, size_b29_q, size_b28_q};
    end

endmodule

// File: rtl/fat32_root_dir_scanner.sv
// -----------------------------------------------------------------------------
// fat32_root_dir_scanner
// Reads SCAN_SECTORS consecutive root-directory sectors starting at
// root_sector and searches for the 8.3 name TARGET_NAME. Reports the first
// cluster, size and location of the first live matching entry.
// Optional macro: FAT32_DIR_CASE_FOLD_EN (case-insensitive name compare,
// implemented in dir_entry_matcher).
//
// Ports:
//   sys_clk, sys_rst_n      : clock, asynchronous active-low reset
//   start, root_sector      : begin a scan (accepted only when idle)
//   rd_req, rd_sector       : sector read request, held until rd_ack
//   rd_ack                  : request accepted, byte stream follows
//   rd_valid, rd_byte       : sector byte stream, byte 0 first
//   busy, done              : scan in progress / one-cycle completion pulse
//   found                   : match result, valid at done, held until start
//   first_cluster, file_size: fields of the matched entry
//   entry_sector, entry_index: location of the matched entry
// -----------------------------------------------------------------------------
module fat32_root_dir_scanner
    import fat32_pkg::*;
#(
    parameter logic [87:0] TARGET_NAME  = 88'h44_41_54_41_20_20_20_20_42_49_4E,
    parameter int          SCAN_SECTORS = 8,
    parameter int          SECTOR_BYTES = 512
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic        start,
    input  logic [31:0] root_sector,
    output logic        rd_req,
    output logic [31:0] rd_sector,
    input  logic        rd_ack,
    input  logic        rd_valid,
    input  logic [7:0]  rd_byte,
    output logic        busy,
    output logic        done,
    output logic        found,
    output logic [31:0] first_cluster,
    output logic [31:0] file_size,
    output logic [31:0] entry_sector,
    output logic [3:0]  entry_index
);

    localparam int          CNT_W     = (SCAN_SECTORS > 1) ? $clog2(SCAN_SECTORS) : 1;
    localparam logic [CNT_W-1:0] LAST_SECTOR = CNT_W'(SCAN_SECTORS - 1);
    localparam logic [8:0]  LAST_BYTE = 9'(SECTOR_BYTES - 1);

    scan_state_e      state_q, state_d;
    logic [31:0]      root_q, root_d;
    logic [CNT_W-1:0] sector_cnt_q, sector_cnt_d;
    logic [8:0]       byte_cnt_q, byte_cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             found_q, found_d;
    logic             end_seen_q, end_seen_d;
    logic [31:0]      first_cluster_q, first_cluster_d;
    logic [31:0]      file_size_q, file_size_d;
    logic [31:0]      entry_sector_q, entry_sector_d;
    logic [3:0]       entry_index_q, entry_index_d;

    logic        beat;
    logic        ent_done, ent_skip, ent_end, ent_match, ent_name_eq;
    logic [31:0] ent_clus, ent_size;

    assign beat = (state_q == ST_STREAM) && rd_valid;

    dir_entry_matcher #(
        .TARGET_NAME (TARGET_NAME)
    ) u_matcher (
        .clk          (sys_clk),
        .beat_i       (beat),
        .ofs_i        (byte_cnt_q[4:0]),
        .byte_i       (rd_byte),
        .entry_done_o (ent_done),
        .skip_o       (ent_skip),
        .end_o        (ent_end),
        .match_o      (ent_match),
        .name_eq_o    (ent_name_eq),
        .clus_o       (ent_clus),
        .size_o       (ent_size)
    );

    assign rd_req        = (state_q == ST_REQ);
    assign rd_sector     = root_q + {{(32-CNT_W){1'b0}}, sector_cnt_q};
    assign busy          = busy_q;
    assign done          = done_q;
    assign found         = found_q;
    assign first_cluster = first_cluster_q;
    assign file_size     = file_size_q;
    assign entry_sector  = entry_sector_q;
    assign entry_index   = entry_index_q;

    always_comb begin
        state_d         = state_q;
        root_d          = root_q;
        sector_cnt_d    = sector_cnt_q;
        byte_cnt_d      = byte_cnt_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        found_d         = found_q;
        end_seen_d      = end_seen_q;
        first_cluster_d = first_cluster_q;
        file_size_d     = file_size_q;
        entry_sector_d  = entry_sector_q;
        entry_index_d   = entry_index_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    root_d       = root_sector;
                    sector_cnt_d = '0;
                    found_d      = 1'b0;
                    end_seen_d   = 1'b0;
                    busy_d       = 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rd_ack) begin
                    byte_cnt_d = '0;
                    state_d    = ST_STREAM;
                end
            end
            ST_STREAM: begin
                if (rd_valid) begin
                    byte_cnt_d = byte_cnt_q + 9'd1;
                    // Only the first hit or terminator counts; later entries
                    // still stream through but are ignored.
                    if (ent_done && !found_q && !end_seen_q) begin
                        if (ent_end) begin
                            end_seen_d = 1'b1;
                        end else if (ent_match && ent_name_eq && !ent_skip) begin
                            found_d         = 1'b1;
                            first_cluster_d = ent_clus;
                            file_size_d     = ent_size;
                            entry_sector_d  = rd_sector;
                            entry_index_d   = byte_cnt_q[8:5];
                        end
                    end
                    if (byte_cnt_q == LAST_BYTE) state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                if (found_q || end_seen_q || sector_cnt_q == LAST_SECTOR) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_DONE;
                end else begin
                    sector_cnt_d = sector_cnt_q + 1'b1;
                    state_d      = ST_REQ;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q         <= ST_IDLE;
            root_q          <= '0;
            sector_cnt_q    <= '0;
            byte_cnt_q      <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            found_q         <= 1'b0;
            end_seen_q      <= 1'b0;
            first_cluster_q <= '0;
            file_size_q     <= '0;
            entry_sector_q  <= '0;
            entry_index_q   <= '0;
        end else begin
            state_q         <= state_d;
            root_q          <= root_d;
            sector_cnt_q    <= sector_cnt_d;
            byte_cnt_q      <= byte_cnt_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            found_q         <= found_d;
            end_seen_q      <= end_seen_d;
            first_cluster_q <= first_cluster_d;
            file_size_q     <= file_size_d;
            entry_sector_q  <= entry_sector_d;
            entry_index_q   <= entry_index_d;
        end
    end

endmodule

// File: tb/tb_fat32_root_dir_scanner.sv
module tb_fat32_root_dir_scanner;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] root_sector = '0;
    logic        rd_req;
    logic [31:0] rd_sector;
    logic        rd_ack = 1'b0;
    logic        rd_valid = 1'b0;
    logic [7:0]  rd_byte = '0;
    logic        busy, done, found;
    logic [31:0] first_cluster, file_size, entry_sector;
    logic [3:0]  entry_index;

    int checks = 0;
    int errors = 0;
    int req_cnt = 0;
    logic req_prev = 1'b0;

    logic [7:0] sec [512];

    localparam logic [87:0] NAME_TGT   = 88'h44_41_54_41_20_20_20_20_42_49_4E;
    localparam logic [87:0] NAME_DEL   = 88'hE5_41_54_41_20_20_20_20_42_49_4E;
    localparam logic [87:0] NAME_OTHER = 88'h4F_54_48_45_52_20_20_20_54_58_54;
    localparam logic [87:0] NAME_LOWER = 88'h64_61_74_61_20_20_20_20_62_69_6E;
    localparam logic [87:0] NAME_FREE  = 88'h0;

    fat32_root_dir_scanner dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .root_sector   (root_sector),
        .rd_req        (rd_req),
        .rd_sector     (rd_sector),
        .rd_ack        (rd_ack),
        .rd_valid      (rd_valid),
        .rd_byte       (rd_byte),
        .busy          (busy),
        .done          (done),
        .found         (found),
        .first_cluster (first_cluster),
        .file_size     (file_size),
        .entry_sector  (entry_sector),
        .entry_index   (entry_index)
    );

    always #5 sys_clk = ~sys_clk;

    // Count rising edges of rd_req (one per issued sector request).
    always @(posedge sys_clk) begin
        req_prev <= rd_req;
        if (rd_req && !req_prev) req_cnt <= req_cnt + 1;
    end

    task automatic put_entry(input int idx, input logic [87:0] name, input logic [7:0] attr,
                             input logic [31:0] clus, input logic [31:0] size);
        int b;
        b = idx * 32;
        for (int k = 0; k < 11; k++) sec[b + k] = name[(10 - k) * 8 +: 8];
        sec[b + 11] = attr;
        for (int k = 12; k < 32; k++) sec[b + k] = 8'h00;
        sec[b + 20] = clus[23:16];
        sec[b + 21] = clus[31:24];
        sec[b + 26] = clus[7:0];
        sec[b + 27] = clus[15:8];
        sec[b + 28] = size[7:0];
        sec[b + 29] = size[15:8];
        sec[b + 30] = size[23:16];
        sec[b + 31] = size[31:24];
    endtask

    task automatic clear_sector();
        for (int e = 0; e < 16; e++) put_entry(e, NAME_OTHER, 8'h20, 32'd9, 32'd100);
    endtask

    task automatic do_start(input logic [31:0] root);
        start = 1'b1;
        root_sector = root;
        @(posedge sys_clk); #1;
        start = 1'b0;
    endtask

    // Wait for a request, check its address, ack it and stream 'nbytes' of sec[].
    // A short rd_valid gap (with a junk byte) is inserted every 128 bytes.
    task automatic serve(input string nm, input logic [31:0] exp_addr, input int nbytes,
                         input int inject_start_at);
        for (int n = 0; n < 50 && !rd_req; n++) begin
            @(posedge sys_clk); #1;
        end
        checks++;
        if (!rd_req) begin
            errors++;
            $display("FAIL %s_req: rd_req=%0b required 1 within 50 cycles", nm, rd_req);
        end else if (rd_sector !== exp_addr) begin
            errors++;
            $display("FAIL %s_addr: rd_sector=%h required %h", nm, rd_sector, exp_addr);
        end
        rd_ack = 1'b1;
        @(posedge sys_clk); #1;
        rd_ack = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            if (i % 128 == 64) begin
                rd_valid = 1'b0;
                rd_byte  = 8'hE5;
                @(posedge sys_clk); #1;
            end
            rd_valid = 1'b1;
            rd_byte  = sec[i];
            if (i == inject_start_at) begin
                start = 1'b1;
                root_sector = 32'h0000_9999;
            end else begin
                start = 1'b0;
            end
            @(posedge sys_clk); #1;
        end
        rd_valid = 1'b0;
        start = 1'b0;
    endtask

    // Called #1 after the edge that took byte 511: EVAL now, DONE next cycle.
    task automatic expect_done(input string nm);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_early: done=%0b required 0", nm, done);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s_done: done=%0b busy=%0b required done=1 busy=0", nm, done, busy);
        end
        @(posedge sys_clk); #1;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL %s_done_pulse: done=%0b required 0", nm, done);
        end
    endtask

    task automatic check_no_req(input string nm);
        logic seen;
        seen = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (rd_req) seen = 1'b1;
            @(posedge sys_clk); #1;
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL %s_extra_req: rd_req seen=%0b required 0", nm, seen);
        end
    endtask

    task automatic build_match_sector();
        clear_sector();
        put_entry(3, NAME_TGT, 8'h20, 32'h0000_0005, 32'h0000_1200);
        put_entry(10, NAME_TGT, 8'h20, 32'h0000_0077, 32'h0000_0001);
    endtask

    task automatic test_reset();
        checks++;
        if ({rd_req, busy, done, found} !== 4'b0 || rd_sector !== 32'h0 || first_cluster !== 32'h0 ||
            file_size !== 32'h0 || entry_sector !== 32'h0 || entry_index !== 4'h0) begin
            errors++;
            $display("FAIL reset_values: req=%0b busy=%0b done=%0b found=%0b sec=%h clus=%h size=%h esec=%h idx=%0d required all 0",
                     rd_req, busy, done, found, rd_sector, first_cluster, file_size, entry_sector, entry_index);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
    endtask

    task automatic test_match_first_sector();
        int base;
        base = req_cnt;
        build_match_sector();
        do_start(32'h0000_4000);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL t1_busy: busy=%0b required 1", busy);
        end
        serve("t1", 32'h0000_4000, 512, 300);
        expect_done("t1");
        checks++;
        if (found !== 1'b1 || first_cluster !== 32'h5 || file_size !== 32'h1200 ||
            entry_sector !== 32'h4000 || entry_index !== 4'd3) begin
            errors++;
            $display("FAIL t1_result: found=%0b clus=%h size=%h esec=%h idx=%0d required 1 5 1200 4000 3",
                     found, first_cluster, file_size, entry_sector, entry_index);
        end
        check_no_req("t1");
        checks++;
        if (req_cnt - base !== 1) begin
            errors++;
            $display("FAIL t1_req_count: requests=%0d required 1", req_cnt - base);
        end
    endtask

    task automatic test_end_marker();
        int base;
        base = req_cnt;
        clear_sector();
        put_entry(2, NAME_FREE, 8'h00, 32'h0, 32'h0);
        put_entry(5, NAME_TGT, 8'h20, 32'h33, 32'h44);
        do_start(32'h0000_4000);
        checks++;
        if (found !== 1'b0) begin
            errors++;
            $display("FAIL t2_found_clear: found=%0b required 0 after start", found);
        end
        serve("t2", 32'h0000_4000, 512, -1);
        expect_done("t2");
        checks++;
        if (found !== 1'b0) begin
            errors++;
            $display("FAIL t2_found: found=%0b required 0", found);
        end
        check_no_req("t2");
        checks++;
        if (req_cnt - base !== 1) begin
            errors++;
            $display("FAIL t2_req_count: requests=%0d required 1", req_cnt - base);
        end
    endtask

    task automatic test_skip_entries();
        clear_sector();
        put_entry(0, NAME_DEL, 8'h20, 32'h11, 32'h11);
        put_entry(1, NAME_TGT, 8'h0F, 32'h22, 32'h22);
        put_entry(2, NAME_TGT, 8'h08, 32'h23, 32'h23);
        do_start(32'h0000_4000);
        serve("t3s0", 32'h0000_4000, 512, -1);
        clear_sector();
        put_entry(15, NAME_TGT, 8'h20, 32'h0001_2345, 32'hDEAD_BEEF);
        serve("t3s1", 32'h0000_4001, 512, -1);
        expect_done("t3");
        checks++;
        if (found !== 1'b1 || first_cluster !== 32'h0001_2345 || file_size !== 32'hDEAD_BEEF ||
            entry_sector !== 32'h4001 || entry_index !== 4'd15) begin
            errors++;
            $display("FAIL t3_result: found=%0b clus=%h size=%h esec=%h idx=%0d required 1 00012345 deadbeef 4001 15",
                     found, first_cluster, file_size, entry_sector, entry_index);
        end
    endtask

    task automatic test_full_scan();
        int base;
        base = req_cnt;
        do_start(32'h0000_4000);
        for (int s = 0; s < 8; s++) begin
            clear_sector();
            serve($sformatf("t4s%0d", s), 32'h0000_4000 + s, 512, -1);
        end
        expect_done("t4");
        checks++;
        if (found !== 1'b0) begin
            errors++;
            $display("FAIL t4_found: found=%0b required 0", found);
        end
        check_no_req("t4");
        checks++;
        if (req_cnt - base !== 8) begin
            errors++;
            $display("FAIL t4_req_count: requests=%0d required 8", req_cnt - base);
        end
    endtask

    task automatic test_wrap();
        int base;
        base = req_cnt;
        do_start(32'hFFFF_FFFF);
        clear_sector();
        serve("t5s0", 32'hFFFF_FFFF, 512, -1);
        clear_sector();
        put_entry(0, NAME_FREE, 8'h00, 32'h0, 32'h0);
        put_entry(1, NAME_TGT, 8'h20, 32'h55, 32'h66);
        serve("t5s1", 32'h0000_0000, 512, -1);
        expect_done("t5");
        checks++;
        if (found !== 1'b0 || req_cnt - base !== 2) begin
            errors++;
            $display("FAIL t5_result: found=%0b requests=%0d required 0 2", found, req_cnt - base);
        end
    endtask

    task automatic test_reset_midstream();
        build_match_sector();
        do_start(32'h0000_4000);
        serve("t6a", 32'h0000_4000, 200, -1);
        sys_rst_n = 1'b0;
        #1;
        checks++;
        if ({rd_req, busy, done, found} !== 4'b0 || rd_sector !== 32'h0 || first_cluster !== 32'h0 ||
            file_size !== 32'h0 || entry_sector !== 32'h0 || entry_index !== 4'h0) begin
            errors++;
            $display("FAIL t6_async_reset: req=%0b busy=%0b done=%0b found=%0b sec=%h clus=%h size=%h esec=%h idx=%0d required all 0",
                     rd_req, busy, done, found, rd_sector, first_cluster, file_size, entry_sector, entry_index);
        end
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        @(posedge sys_clk); #1;
        do_start(32'h0000_4000);
        serve("t6b", 32'h0000_4000, 512, -1);
        expect_done("t6b");
        checks++;
        if (found !== 1'b1 || first_cluster !== 32'h5 || entry_index !== 4'd3) begin
            errors++;
            $display("FAIL t6_rescan: found=%0b clus=%h idx=%0d required 1 5 3", found, first_cluster, entry_index);
        end
    endtask

    task automatic test_case_fold();
        logic exp_found;
`ifdef FAT32_DIR_CASE_FOLD_EN
        exp_found = 1'b1;
`else
        exp_found = 1'b0;
`endif
        clear_sector();
        put_entry(5, NAME_LOWER, 8'h20, 32'h0000_0042, 32'h0000_0010);
        put_entry(6, NAME_FREE, 8'h00, 32'h0, 32'h0);
        do_start(32'h0000_4000);
        serve("t7", 32'h0000_4000, 512, -1);
        expect_done("t7");
        checks++;
        if (found !== exp_found) begin
            errors++;
            $display("FAIL t7_fold_found: found=%0b required %0b", found, exp_found);
        end
        if (exp_found) begin
            checks++;
            if (first_cluster !== 32'h42 || entry_index !== 4'd5) begin
                errors++;
                $display("FAIL t7_fold_fields: clus=%h idx=%0d required 42 5", first_cluster, entry_index);
            end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_match_first_sector();
        test_end_marker();
        test_skip_entries();
        test_full_scan();
        test_wrap();
        test_reset_midstream();
        test_case_fold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
